// File: rtl/decode_pkg_r32i.sv
// Shared RV32I decode definitions: opcodes, ALU codes, instruction classes and the decoded entry layout.
package decode_pkg_r32i;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SLT  = 4'd1,
    ALU_SLTU = 4'd2,
    ALU_XOR  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_AND  = 4'd5,
    ALU_SSL  = 4'd6,
    ALU_SSR  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_CPY  = 4'd9
  } alucode_e;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_LOAD   = 3'd1,
    CLS_STORE  = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_JAL    = 3'd4,
    CLS_JALR   = 3'd5,
    CLS_LUIPC  = 3'd6,
    CLS_SYSTEM = 3'd7
  } class_e;

  typedef struct packed {
    alucode_e          alucode;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] imm;
    logic              a_sel;
    logic              b_sel;
    logic              b_neg;
    logic              rd_we;
    class_e            cls;
    logic [2:0]        funct3;
    logic [DATA_W-1:0] pc;
    logic              illegal;
  } decoded_t;

  // funct3 to ALU function for OP / OP-IMM; bit30 picks arithmetic right shift
  function automatic alucode_e alu_from_f3(input logic [2:0] f3, input logic bit30);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SSL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return bit30 ? ALU_SRA : ALU_SSR;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/skid_buffer_r32i.sv
// Generic 2-entry valid/ready skid buffer; in_ready is a flop output and order is preserved.
module skid_buffer_r32i #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         nReset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] main_data_q, main_data_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         ready_q, ready_d;
  logic         in_xfer, out_xfer;

  // Next-state: flush wins; a free or draining main takes skid first, then new input
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    in_xfer      = in_valid & ready_q;
    out_xfer     = main_valid_q & out_ready;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_xfer) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = in_xfer;
        if (in_xfer) main_data_d = in_data;
      end
    end else if (in_xfer) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
    ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
      ready_q      <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
      ready_q      <= ready_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;

endmodule

// File: rtl/decode_stage_r32i.sv
// RV32I decode stage: combinational decode of {instr, pc} registered through a 2-entry skid buffer.
module decode_stage_r32i
  import decode_pkg_r32i::*;
#(
  parameter int unsigned dataW = 32
) (
  input  logic             clock,
  input  logic             nReset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [dataW-1:0] pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_alucode,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [dataW-1:0] out_imm,
  output logic             out_a_sel,
  output logic             out_b_sel,
  output logic             out_b_neg,
  output logic             out_rd_we,
  output logic [2:0]       out_class,
  output logic [2:0]       out_funct3,
  output logic [dataW-1:0] out_pc,
  output logic             out_illegal
);

  localparam int unsigned DEC_W = $bits(decoded_t);

  logic [6:0]        opcode;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic [DATA_W-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic              ill, we;
  decoded_t          dec, q;
  logic [DEC_W-1:0]  skid_q;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Register fields and funct3 pass through raw; illegal entries collapse to a harmless SYSTEM/ADD
  always_comb begin
    dec        = '0;
    dec.rs1    = instr[19:15];
    dec.rs2    = instr[24:20];
    dec.rd     = instr[11:7];
    dec.funct3 = f3;
    dec.pc     = DATA_W'(pc);
    dec.alucode = ALU_ADD;
    dec.cls    = CLS_SYSTEM;
    ill        = 1'b0;
    we         = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.cls     = CLS_ALU;
        dec.alucode = alu_from_f3(f3, instr[30]);
        dec.b_neg   = (f3 == 3'b000) && (f7 == 7'h20);
        we          = 1'b1;
        ill = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      OPC_OP_IMM: begin
        dec.cls     = CLS_ALU;
        dec.alucode = alu_from_f3(f3, instr[30]);
        dec.b_sel   = 1'b1;
        we          = 1'b1;
        if (f3 == 3'b001) begin
          dec.imm = DATA_W'(instr[24:20]);
          ill     = (f7 != 7'h00);
        end else if (f3 == 3'b101) begin
          dec.imm = DATA_W'(instr[24:20]);
          ill     = (f7 != 7'h00) && (f7 != 7'h20);
        end else begin
          dec.imm = imm_i;
        end
      end
      OPC_LUI: begin
        dec.cls     = CLS_LUIPC;
        dec.alucode = ALU_CPY;
        dec.b_sel   = 1'b1;
        dec.imm     = imm_u;
        we          = 1'b1;
      end
      OPC_AUIPC: begin
        dec.cls   = CLS_LUIPC;
        dec.a_sel = 1'b1;
        dec.b_sel = 1'b1;
        dec.imm   = imm_u;
        we        = 1'b1;
      end
      OPC_LOAD: begin
        dec.cls   = CLS_LOAD;
        dec.b_sel = 1'b1;
        dec.imm   = imm_i;
        we        = 1'b1;
      end
      OPC_STORE: begin
        dec.cls   = CLS_STORE;
        dec.b_sel = 1'b1;
        dec.imm   = imm_s;
      end
      OPC_BRANCH: begin
        dec.cls = CLS_BRANCH;
        dec.imm = imm_b;
        case (f3)
          3'b000, 3'b001: dec.alucode = ALU_XOR;
          3'b100, 3'b101: dec.alucode = ALU_SLT;
          3'b110, 3'b111: dec.alucode = ALU_SLTU;
          default:        ill = 1'b1;
        endcase
      end
      OPC_JAL: begin
        dec.cls   = CLS_JAL;
        dec.a_sel = 1'b1;
        dec.b_sel = 1'b1;
        dec.imm   = imm_j;
        we        = 1'b1;
      end
      OPC_JALR: begin
        dec.cls   = CLS_JALR;
        dec.b_sel = 1'b1;
        dec.imm   = imm_i;
        we        = 1'b1;
        ill       = (f3 != 3'b000);
      end
      OPC_MISC_MEM: dec.cls = CLS_SYSTEM;
      // Only ECALL and EBREAK are recognised here; CSR forms are not RV32I base
      OPC_SYSTEM: ill = (instr[31:21] != 11'd0) || (instr[19:7] != 13'd0);
      default: ill = 1'b1;
    endcase
    if (ill) begin
      dec.alucode = ALU_ADD;
      dec.cls     = CLS_SYSTEM;
      dec.imm     = '0;
      dec.a_sel   = 1'b0;
      dec.b_sel   = 1'b0;
      dec.b_neg   = 1'b0;
      we          = 1'b0;
    end
    dec.illegal = ill;
    dec.rd_we   = we && (instr[11:7] != 5'd0);
  end

  skid_buffer_r32i #(
    .W(DEC_W)
  ) u_skid (
    .clock     (clock),
    .nReset    (nReset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (skid_q)
  );

  assign q           = skid_q;
  assign out_alucode = q.alucode;
  assign out_rs1     = q.rs1;
  assign out_rs2     = q.rs2;
  assign out_rd      = q.rd;
  assign out_imm     = dataW'(q.imm);
  assign out_a_sel   = q.a_sel;
  assign out_b_sel   = q.b_sel;
  assign out_b_neg   = q.b_neg;
  assign out_rd_we   = q.rd_we;
  assign out_class   = q.cls;
  assign out_funct3  = q.funct3;
  assign out_pc      = dataW'(q.pc);
  assign out_illegal = q.illegal;

endmodule
